add32_seq_arbiter: RTL and testbench

Shares a single add16 slice among NREQ requesters. Each granted request is a 32-bit add executed over two cycles: the low half with carry-in 0, then the high half with the stored carry. Requesters are arbitrated round-robin, and results return on one valid/ready response channel tagged with the requester id. Used where area matters more than add throughput.

---
 rtl/add32_seq_arbiter_pkg.sv | 14 +
 rtl/add32_seq_arbiter_add16.sv | 15 +
 rtl/add32_seq_arbiter.sv | 146 ++++++++++++++
 tb/tb_add32_seq_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/add32_seq_arbiter_pkg.sv
// Shared types and widths for the sequential 32-bit add arbiter.
package add32_seq_arbiter_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/add32_seq_arbiter_add16.sv
// 16-bit ripple adder slice with carry in/out.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Plain 17-bit addition; carry lands in the top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
  end

endmodule

// File: rtl/add32_seq_arbiter.sv
// Round-robin arbiter sharing one add16 slice across NREQ requesters.
// Each grant performs a 32-bit add over two cycles (low half, then high half).
module add32_seq_arbiter
  import add32_seq_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic [IDW-1:0]         rsp_id
);

  // Pointer reset value makes requester 0 the first candidate searched.
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   a_q, a_d;
  logic [WORD_W-1:0]   b_q, b_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                carry_q, carry_d;

  logic [HALF_W-1:0]   add_a, add_b, add_sum;
  logic                add_cin, add_cout;
  logic [IDW-1:0]      grant;

  // First valid index after `last`, wrapping; nearest candidate wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int unsigned    idx;
    pick = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = (32'(last) + k) % NREQ;
      if (v[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  add16 u_add16 (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Half selection for the shared adder: low half in LO, high half otherwise.
  always_comb begin
    if (state_q == ST_LO) begin
      add_a   = a_q[HALF_W-1:0];
      add_b   = b_q[HALF_W-1:0];
      add_cin = 1'b0;
    end else begin
      add_a   = a_q[WORD_W-1:HALF_W];
      add_b   = b_q[WORD_W-1:HALF_W];
      add_cin = (state_q == ST_HI) ? carry_q : 1'b0;
    end
  end

  // Next-state, capture and grant strobe logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    last_d    = last_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    carry_d   = carry_q;
    req_ready = '0;
    grant     = rr_pick(req_valid, last_q);
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant) begin
              req_ready[i] = 1'b1;
              a_d          = req_a[i*WORD_W +: WORD_W];
              b_d          = req_b[i*WORD_W +: WORD_W];
            end
          end
          id_d    = grant;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        sum_d[HALF_W-1:0] = add_sum;
        carry_d           = add_cout;
        state_d           = ST_HI;
      end
      ST_HI: begin
        sum_d[WORD_W-1:HALF_W] = add_sum;
        cout_d                 = add_cout;
        state_d                = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      last_q  <= LAST_RST;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_add32_seq_arbiter.sv
// Directed and randomized bench for add32_seq_arbiter with a behavioural model.
module tb_add32_seq_arbiter;

  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [63:0]     req_a;
  logic [63:0]     req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_sum;
  logic            rsp_cout;
  logic [0:0]      rsp_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: id of the last completed grant, issue-gap tracking.
  int model_last;
  int prev_gc;
  int prev_stall;
  bit chain;

  add32_seq_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Round-robin rule: first valid requester after the last served one.
  function automatic int model_pick(input logic [1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
    return -1;
  endfunction

  // One full transaction starting in IDLE; operands are scrambled after grant.
  task automatic do_txn(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input int stall);
    int          g;
    logic [31:0] ea, eb;
    logic [32:0] exp_sum;
    req_valid = vld;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = 1'b1;
    #1;
    g       = model_pick(vld);
    ea      = (g == 1) ? a1 : a0;
    eb      = (g == 1) ? b1 : b0;
    exp_sum = {1'b0, ea} + {1'b0, eb};
    check("grant", req_ready, 64'(2'b01 << g));
    check("idle_rsp_valid", rsp_valid, 0);
    if (chain) check("issue_gap", cyc - prev_gc, 4 + prev_stall);
    prev_gc = cyc;
    tick();
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    #1;
    check("lo_ready", req_ready, 0);
    check("lo_valid", rsp_valid, 0);
    tick();
    #1;
    check("hi_ready", req_ready, 0);
    check("hi_valid", rsp_valid, 0);
    tick();
    if (stall > 0) rsp_ready = 1'b0;
    #1;
    check("resp_valid", rsp_valid, 1);
    check("resp_sum", rsp_sum, exp_sum[31:0]);
    check("resp_cout", rsp_cout, exp_sum[32]);
    check("resp_id", rsp_id, g);
    check("resp_ready", req_ready, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_sum", rsp_sum, exp_sum[31:0]);
      check("hold_cout", rsp_cout, exp_sum[32]);
      check("hold_id", rsp_id, g);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("post_valid", rsp_valid, 0);
    model_last = g;
    prev_stall = stall;
    chain      = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    model_last = NREQ - 1;
    chain      = 1'b0;
    prev_gc    = 0;
    prev_stall = 0;
    tick();
    tick();
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_cout", rsp_cout, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
    tick();
    #1;
    check("idle_noreq_ready", req_ready, 0);

    // Carry between halves, full wrap, and high-bit overflow.
    do_txn(2'b01, 32'h0000FFFF, 32'h00000001, 32'h0, 32'h0, 0);
    do_txn(2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 0);
    do_txn(2'b01, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 0);

    // Both requesters continuously valid: alternating grants.
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, $urandom, $urandom, $urandom, $urandom, 0);

    // Backpressure held five cycles, then next grant follows the accept.
    do_txn(2'b11, 32'h12345678, 32'h9ABCDEF0, 32'hFFFF0000, 32'h00010000, 5);
    do_txn(2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 0);

    // Reset during HI drops the transaction and restores the pointer.
    do_txn(2'b01, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 0);
    req_valid = 2'b10;
    req_a     = {32'h0000FFFF, 32'h0};
    req_b     = {32'h00000001, 32'h0};
    #1;
    check("pre_rst_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    model_last = NREQ - 1;
    chain      = 1'b0;
    #1;
    check("after_rst_valid", rsp_valid, 0);
    check("after_rst_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("dropped_no_rsp", rsp_valid, 0);
    end
    do_txn(2'b11, 32'hA, 32'hB, 32'hC, 32'hD, 0);
    check("ptr_reset_owner", model_last, 0);

    // Randomized traffic with occasional backpressure.
    for (int i = 0; i < 12; i++)
      do_txn(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
